// File: rtl/if_slice_if.sv
// if_slice_if: instruction-memory request/response bus between the fetch
// stage and the instruction memory.
//   imem_req   : fetch request valid (fetch -> memory)
//   imem_addr  : 16-bit word address, stable while imem_req=1 until imem_ack
//   imem_ack   : imem_rdata valid; completes the outstanding request
//   imem_rdata : fetched 16-bit instruction word
// Modports: master = fetch stage, slave = instruction memory.
interface if_slice_if;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/if_slice.sv
// if_slice: instruction-fetch stage of the 5-stage pipeline. Owns the PC,
// issues word-addressed fetches over a variable-latency memory bus, takes
// redirects from decode (Call/PCcall) and from the resolution stage
// (redir/redir_pc), holds its output under stall and injects FLUSH bubbles
// whenever no valid instruction is available.
//
// Ports:
//   clk       : clock, all state updates on posedge
//   rst       : synchronous active-low reset
//   imem      : instruction-memory bus (if_slice_if.master)
//   stall     : hold instr/PC_inc, accept no new fetch result
//   Call      : decode has a CALL, redirect to PCcall (ignored under stall)
//   PCcall    : call target
//   redir     : taken branch / return resolved later; wins over Call
//   redir_pc  : redirect target
//   instr     : registered instruction word to decode (BUBBLE if none)
//   PC_inc    : registered address of instr plus 1 (0 with a bubble)
//   halted    : fetch stopped after delivering a HLT word
//
// Configuration:
//   IF_HALT_DETECT_EN : when defined, a delivered 16'hFFFF word stops fetch
//                       (state HALTED, halted=1) until reset. When undefined,
//                       16'hFFFF is an ordinary word and halted stays 0.
module if_slice #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] BUBBLE   = 16'hF000
) (
    input  logic              clk,
    input  logic              rst,
    if_slice_if.master        imem,
    input  logic              stall,
    input  logic              Call,
    input  logic [15:0]       PCcall,
    input  logic              redir,
    input  logic [15:0]       redir_pc,
    output logic [15:0]       instr,
    output logic [15:0]       PC_inc,
    output logic              halted
);

    localparam int unsigned W = 16;
    localparam logic [W-1:0] HLT_WORD = 16'hFFFF;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } state_e;

    state_e       state;
    logic [W-1:0] pc;         // next address to fetch (redirect target while draining)
    logic [W-1:0] addr_q;     // address presented on the bus
    logic         req_q;
    logic [W-1:0] buf_word;   // word captured under stall
    logic [W-1:0] buf_pc;     // address of buf_word
    logic [W-1:0] instr_q;
    logic [W-1:0] pc_inc_q;
    logic         halted_q;

    logic         redirect_c;
    logic [W-1:0] target_c;
    logic         rdata_hlt_c;
    logic         buf_hlt_c;

    // Redirect selection: redir always wins; Call only counts when decode is not stalled.
    assign redirect_c = redir | (Call & ~stall);
    assign target_c   = redir ? redir_pc : PCcall;

    // HLT detection on the word about to be delivered (bus or stall buffer).
`ifdef IF_HALT_DETECT_EN
    assign rdata_hlt_c = (imem.imem_rdata == HLT_WORD);
    assign buf_hlt_c   = (buf_word == HLT_WORD);
`else
    assign rdata_hlt_c = 1'b0;
    assign buf_hlt_c   = 1'b0;
`endif

    // Fetch FSM with registered bus and decode-side outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            addr_q   <= RESET_PC;
            req_q    <= 1'b1;
            buf_word <= BUBBLE;
            buf_pc   <= '0;
            instr_q  <= BUBBLE;
            pc_inc_q <= '0;
            halted_q <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (redirect_c) begin
                        pc       <= target_c;
                        instr_q  <= BUBBLE;
                        pc_inc_q <= '0;
                        if (imem.imem_ack) begin
                            // Request completes now; its data is dropped.
                            addr_q <= target_c;
                        end else begin
                            // Keep the abandoned address on the bus until it is acked.
                            state  <= DRAIN;
                        end
                    end else if (imem.imem_ack) begin
                        if (!stall) begin
                            instr_q  <= imem.imem_rdata;
                            pc_inc_q <= pc + 16'd1;
                            pc       <= pc + 16'd1;
                            addr_q   <= pc + 16'd1;
                            if (rdata_hlt_c) begin
                                state    <= HALTED;
                                req_q    <= 1'b0;
                                halted_q <= 1'b1;
                            end
                        end else begin
                            buf_word <= imem.imem_rdata;
                            buf_pc   <= pc;
                            req_q    <= 1'b0;
                            state    <= HOLD;
                        end
                    end else if (!stall) begin
                        instr_q  <= BUBBLE;
                        pc_inc_q <= '0;
                    end
                end

                HOLD: begin
                    if (redirect_c) begin
                        // Buffered word is discarded by leaving HOLD.
                        pc       <= target_c;
                        addr_q   <= target_c;
                        req_q    <= 1'b1;
                        instr_q  <= BUBBLE;
                        pc_inc_q <= '0;
                        state    <= FETCH;
                    end else if (!stall) begin
                        instr_q  <= buf_word;
                        pc_inc_q <= buf_pc + 16'd1;
                        pc       <= buf_pc + 16'd1;
                        addr_q   <= buf_pc + 16'd1;
                        if (buf_hlt_c) begin
                            halted_q <= 1'b1;
                            state    <= HALTED;
                        end else begin
                            req_q    <= 1'b1;
                            state    <= FETCH;
                        end
                    end
                end

                DRAIN: begin
                    if (redirect_c) begin
                        pc <= target_c;
                    end
                    if (imem.imem_ack) begin
                        // Stale data discarded; restart at the (possibly newer) target.
                        addr_q <= redirect_c ? target_c : pc;
                        state  <= FETCH;
                    end
                    if (redirect_c || !stall) begin
                        instr_q  <= BUBBLE;
                        pc_inc_q <= '0;
                    end
                end

                HALTED: begin
                    req_q    <= 1'b0;
                    instr_q  <= BUBBLE;
                    pc_inc_q <= '0;
                end

                default: begin
                    state    <= FETCH;
                    req_q    <= 1'b1;
                    addr_q   <= pc;
                    instr_q  <= BUBBLE;
                    pc_inc_q <= '0;
                end
            endcase
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = addr_q;
    assign instr          = instr_q;
    assign PC_inc         = pc_inc_q;
    assign halted         = halted_q;

endmodule

// File: tb/tb_if_slice.sv
// tb_if_slice: directed bench for if_slice. A behavioural memory answers
// imem_addr + 16'h1000 after a programmable number of wait cycles (0 =
// ack in the request cycle); it can also plant 16'hFFFF at address 3.
module tb_if_slice;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        Call;
    logic [15:0] PCcall;
    logic        redir;
    logic [15:0] redir_pc;
    logic [15:0] instr;
    logic [15:0] PC_inc;
    logic        halted;

    int          lat;
    int          wait_cnt;
    logic        hlt_en;
    int          n_checks;
    int          n_pass;

    if_slice_if mem ();

    if_slice dut (
        .clk      (clk),
        .rst      (rst),
        .imem     (mem),
        .stall    (stall),
        .Call     (Call),
        .PCcall   (PCcall),
        .redir    (redir),
        .redir_pc (redir_pc),
        .instr    (instr),
        .PC_inc   (PC_inc),
        .halted   (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: ack once the request has waited lat cycles.
    always_comb begin
        mem.imem_ack   = mem.imem_req && (wait_cnt >= lat);
        mem.imem_rdata = (hlt_en && mem.imem_addr == 16'h0003) ? 16'hFFFF
                                                               : mem.imem_addr + 16'h1000;
    end

    always_ff @(posedge clk) begin
        if (!rst || !mem.imem_req || mem.imem_ack) wait_cnt <= 0;
        else                                       wait_cnt <= wait_cnt + 1;
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        lat      = 0;
        hlt_en   = 1'b0;
        rst      = 1'b0;
        stall    = 1'b0;
        Call     = 1'b0;
        PCcall   = 16'h0000;
        redir    = 1'b0;
        redir_pc = 16'h0000;

        // Reset state
        repeat (2) tick();
        check("rst_instr", instr, 16'hF000);
        check("rst_pcinc", PC_inc, 16'h0000);
        check("rst_halted", {15'd0, halted}, 16'h0000);
        check("rst_req", {15'd0, mem.imem_req}, 16'h0001);
        check("rst_addr", mem.imem_addr, 16'h0000);
        rst = 1'b1;

        // Zero-wait streaming
        for (int i = 0; i < 3; i++) begin
            check("zw_addr", mem.imem_addr, 16'(i));
            tick();
            check("zw_instr", instr, 16'h1000 + 16'(i));
            check("zw_pcinc", PC_inc, 16'(i + 1));
        end

        // Three-cycle latency at addr 3: two bubbles, then the word
        lat = 2;
        tick();
        check("lat_b1", instr, 16'hF000);
        check("lat_a1", mem.imem_addr, 16'h0003);
        tick();
        check("lat_b2", instr, 16'hF000);
        check("lat_a2", mem.imem_addr, 16'h0003);
        tick();
        check("lat_instr", instr, 16'h1003);
        check("lat_pcinc", PC_inc, 16'h0004);
        lat = 0;
        tick();
        check("w4_instr", instr, 16'h1004);

        // Stall for 2 cycles during the ack of addr 5
        check("st_addr5", mem.imem_addr, 16'h0005);
        stall = 1'b1;
        tick();
        check("st_hold1", instr, 16'h1004);
        check("st_pcinc1", PC_inc, 16'h0005);
        check("st_req0", {15'd0, mem.imem_req}, 16'h0000);
        tick();
        check("st_hold2", instr, 16'h1004);
        stall = 1'b0;
        tick();
        check("st_word5", instr, 16'h1005);
        check("st_pcinc6", PC_inc, 16'h0006);
        check("st_addr6", mem.imem_addr, 16'h0006);

        // Call redirect
        Call   = 1'b1;
        PCcall = 16'h0040;
        tick();
        Call = 1'b0;
        check("call_bub", instr, 16'hF000);
        check("call_pcinc", PC_inc, 16'h0000);
        check("call_addr", mem.imem_addr, 16'h0040);
        tick();
        check("call_word", instr, 16'h1040);
        check("call_pcinc2", PC_inc, 16'h0041);

        // redir beats a simultaneous Call
        Call     = 1'b1;
        PCcall   = 16'h0040;
        redir    = 1'b1;
        redir_pc = 16'h0080;
        tick();
        Call  = 1'b0;
        redir = 1'b0;
        check("prio_bub", instr, 16'hF000);
        check("prio_addr", mem.imem_addr, 16'h0080);
        tick();
        check("prio_word", instr, 16'h1080);

        // Call ignored under stall
        stall = 1'b1;
        Call  = 1'b1;
        tick();
        check("cst_hold", instr, 16'h1080);
        stall = 1'b0;
        Call  = 1'b0;
        tick();
        check("cst_word", instr, 16'h1081);
        check("cst_addr", mem.imem_addr, 16'h0082);

        // Redirect with the request to addr 9 outstanding -> DRAIN
        redir    = 1'b1;
        redir_pc = 16'h0009;
        tick();
        redir = 1'b0;
        check("dr_addr9", mem.imem_addr, 16'h0009);
        lat      = 2;
        redir    = 1'b1;
        redir_pc = 16'h00A0;
        tick();
        redir = 1'b0;
        check("dr_bub1", instr, 16'hF000);
        check("dr_hold1", mem.imem_addr, 16'h0009);
        check("dr_req", {15'd0, mem.imem_req}, 16'h0001);
        tick();
        check("dr_hold2", mem.imem_addr, 16'h0009);
        tick();
        check("dr_discard", instr, 16'hF000);
        check("dr_target", mem.imem_addr, 16'h00A0);
        lat = 0;
        tick();
        check("dr_word", instr, 16'h10A0);
        check("dr_pcinc", PC_inc, 16'h00A1);

        // redir honoured while stalled in HOLD
        stall = 1'b1;
        tick();
        check("rh_hold", instr, 16'h10A0);
        redir    = 1'b1;
        redir_pc = 16'h00C0;
        tick();
        redir = 1'b0;
        check("rh_bub", instr, 16'hF000);
        check("rh_addr", mem.imem_addr, 16'h00C0);
        stall = 1'b0;
        tick();
        check("rh_word", instr, 16'h10C0);

        // PC wrap FFFF -> 0000
        redir    = 1'b1;
        redir_pc = 16'hFFFF;
        tick();
        redir = 1'b0;
        tick();
        check("wrap_instr", instr, 16'h0FFF);
        check("wrap_pcinc", PC_inc, 16'h0000);
        check("wrap_addr", mem.imem_addr, 16'h0000);

        // HLT word at addr 3
        hlt_en   = 1'b1;
        redir    = 1'b1;
        redir_pc = 16'h0002;
        tick();
        redir = 1'b0;
        tick();
        check("hlt_pre", instr, 16'h1002);
        tick();
        check("hlt_word", instr, 16'hFFFF);
        check("hlt_pcinc", PC_inc, 16'h0004);
`ifdef IF_HALT_DETECT_EN
        check("hlt_halted", {15'd0, halted}, 16'h0001);
        check("hlt_req", {15'd0, mem.imem_req}, 16'h0000);
        tick();
        check("hlt_bub", instr, 16'hF000);
        check("hlt_stay", {15'd0, halted}, 16'h0001);
`else
        check("hlt_halted", {15'd0, halted}, 16'h0000);
        check("hlt_req", {15'd0, mem.imem_req}, 16'h0001);
        tick();
        check("hlt_next", instr, 16'h1004);
`endif
        hlt_en = 1'b0;

        // Reset with a request outstanding
        lat = 2;
        tick();
        rst = 1'b0;
        tick();
        check("mr_instr", instr, 16'hF000);
        check("mr_addr", mem.imem_addr, 16'h0000);
        check("mr_halted", {15'd0, halted}, 16'h0000);
        lat = 0;
        rst = 1'b1;
        tick();
        check("mr_word", instr, 16'h1000);
        check("mr_pcinc", PC_inc, 16'h0001);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
